// File: rtl/ctu_clsp_pkg.sv
// rtl/ctu_clsp_pkg.sv - shared types and cluster indices for the clock-spine cken sequencer
package ctu_clsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } clsp_state_e;

    localparam int CTU_NUM_CKEN = 9;

    localparam int CKEN_DBG    = 0;
    localparam int CKEN_MISC   = 1;
    localparam int CKEN_JBUSL  = 2;
    localparam int CKEN_JBUSR  = 3;
    localparam int CKEN_JBI    = 4;
    localparam int CKEN_IOB    = 5;
    localparam int CKEN_EFC    = 6;
    localparam int CKEN_DRAM02 = 7;
    localparam int CKEN_DRAM13 = 8;

endpackage

// File: rtl/ctu_clsp_gap_cnt.sv
// rtl/ctu_clsp_gap_cnt.sv - loadable stagger-gap down-counter, flags the last cycle of a step
module ctu_clsp_gap_cnt #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    output logic             step_end_o
);

    logic [GAP_W-1:0] count_q;
    logic [GAP_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign step_end_o = (count_q == GAP_W'(1));

endmodule

// File: rtl/ctu_clsp_cken_seq_jl.sv
// rtl/ctu_clsp_cken_seq_jl.sv - jbus cluster clock-enable ramp sequencer; CTU_CLSP_CKEN_STAGGER_EN enables the staggered ramp
module ctu_clsp_cken_seq_jl
    import ctu_clsp_pkg::*;
#(
    parameter int GAP_W = 4
) (
    input  logic             jbus_clk,
    input  logic             io_pwron_rst_l,
    input  logic             start_clk_jl,
    input  logic             stop_req_jl,
    input  logic [8:0]       cken_mask_jl,
    input  logic [GAP_W-1:0] cken_gap_jl,
    output logic             ctu_dbg_cken_pre_jl,
    output logic             ctu_misc_cken_pre_jl,
    output logic             ctu_jbusl_cken_pre_jl,
    output logic             ctu_jbusr_cken_pre_jl,
    output logic             ctu_jbi_cken_pre_jl,
    output logic             ctu_iob_cken_pre_jl,
    output logic             ctu_efc_cken_pre_jl,
    output logic             ctu_dram02_cken_pre_jl,
    output logic             ctu_dram13_cken_pre_jl,
    output logic             clsp_ctrl_srarm_pre_jl,
    output logic             seq_done_jl
);

    localparam logic [3:0] IDX_LAST = 4'(CTU_NUM_CKEN - 1);

    clsp_state_e             state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [CTU_NUM_CKEN-1:0] on_q, on_d;
    logic [CTU_NUM_CKEN-1:0] cken_q;
    logic                    start_prev_q;
    logic                    run_entry_q, run_entry_d;
    logic                    srarm_q;
    logic                    done_q;
    logic                    cnt_load;
    logic                    step_end;
    logic [GAP_W-1:0]        gap_eff;
    logic [3:0]              idx_inc;
    logic [3:0]              idx_dec;

    assign gap_eff = (cken_gap_jl == '0) ? GAP_W'(1) : cken_gap_jl;
    assign idx_inc = idx_q + 4'd1;
    assign idx_dec = idx_q - 4'd1;

    ctu_clsp_gap_cnt #(
        .GAP_W (GAP_W)
    ) u_gap_cnt (
        .clk        (jbus_clk),
        .rst_n      (io_pwron_rst_l),
        .load_i     (cnt_load),
        .load_val_i (gap_eff),
        .step_end_o (step_end)
    );

`ifndef CTU_CLSP_CKEN_STAGGER_EN
    logic step_end_unused;
    assign step_end_unused = step_end;
`endif

    // Each step's start action happens on the edge that ends the previous step,
    // so consecutive enables are exactly G cycles apart.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        on_d        = on_q;
        cnt_load    = 1'b0;
        run_entry_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                on_d = '0;
                if (start_clk_jl && !start_prev_q) begin
                    state_d = ST_RAMP;
                    idx_d   = 4'd0;
`ifdef CTU_CLSP_CKEN_STAGGER_EN
                    on_d[0]  = 1'b1;
                    cnt_load = 1'b1;
`else
                    on_d = '1;
`endif
                end
            end
            ST_RAMP: begin
`ifdef CTU_CLSP_CKEN_STAGGER_EN
                if (step_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_RUN;
                        run_entry_d = 1'b1;
                    end else begin
                        idx_d         = idx_inc;
                        on_d[idx_inc] = 1'b1;
                        cnt_load      = 1'b1;
                    end
                end
`else
                state_d     = ST_RUN;
                run_entry_d = 1'b1;
`endif
            end
            ST_RUN: begin
                if (stop_req_jl) begin
                    state_d = ST_DRAIN;
                    idx_d   = IDX_LAST;
`ifdef CTU_CLSP_CKEN_STAGGER_EN
                    on_d[IDX_LAST] = 1'b0;
                    cnt_load       = 1'b1;
`else
                    on_d = '0;
`endif
                end
            end
            ST_DRAIN: begin
`ifdef CTU_CLSP_CKEN_STAGGER_EN
                if (step_end) begin
                    if (idx_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d         = idx_dec;
                        on_d[idx_dec] = 1'b0;
                        cnt_load      = 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                on_d    = '0;
            end
        endcase

        // Losing start_clk_jl collapses everything regardless of state.
        if (!start_clk_jl) begin
            state_d     = ST_IDLE;
            idx_d       = 4'd0;
            on_d        = '0;
            cnt_load    = 1'b0;
            run_entry_d = 1'b0;
        end
    end

    // start_prev resets high so a start level held through reset cannot launch a ramp.
    always_ff @(posedge jbus_clk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            on_q         <= '0;
            start_prev_q <= 1'b1;
            run_entry_q  <= 1'b0;
            cken_q       <= '0;
            srarm_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            on_q         <= on_d;
            start_prev_q <= start_clk_jl;
            run_entry_q  <= run_entry_d;
            cken_q       <= on_q & cken_mask_jl;
            srarm_q      <= (state_q == ST_RUN);
            done_q       <= run_entry_q;
        end
    end

    assign ctu_dbg_cken_pre_jl    = cken_q[CKEN_DBG];
    assign ctu_misc_cken_pre_jl   = cken_q[CKEN_MISC];
    assign ctu_jbusl_cken_pre_jl  = cken_q[CKEN_JBUSL];
    assign ctu_jbusr_cken_pre_jl  = cken_q[CKEN_JBUSR];
    assign ctu_jbi_cken_pre_jl    = cken_q[CKEN_JBI];
    assign ctu_iob_cken_pre_jl    = cken_q[CKEN_IOB];
    assign ctu_efc_cken_pre_jl    = cken_q[CKEN_EFC];
    assign ctu_dram02_cken_pre_jl = cken_q[CKEN_DRAM02];
    assign ctu_dram13_cken_pre_jl = cken_q[CKEN_DRAM13];
    assign clsp_ctrl_srarm_pre_jl = srarm_q;
    assign seq_done_jl            = done_q;

endmodule

// File: tb/tb_ctu_clsp_cken_seq_jl.sv
// tb/tb_ctu_clsp_cken_seq_jl.sv - randomized scoreboard bench for the cken ramp sequencer
module tb_ctu_clsp_cken_seq_jl;

    localparam int MI = 0;
    localparam int MU = 1;
    localparam int MR = 2;
    localparam int MD = 3;
`ifdef CTU_CLSP_CKEN_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [8:0] mask = 9'h1FF;
    logic [3:0] gap = 4'd1;

    logic dbg, misc, jbusl, jbusr, jbi, iob, efc, dram02, dram13, srarm, done;
    logic [10:0] act;
    assign act = {dram13, dram02, efc, iob, jbi, jbusr, jbusl, misc, dbg, srarm, done};

    always #5 clk = ~clk;

    ctu_clsp_cken_seq_jl #(.GAP_W(4)) dut (
        .jbus_clk               (clk),
        .io_pwron_rst_l         (rst_n),
        .start_clk_jl           (start),
        .stop_req_jl            (stop),
        .cken_mask_jl           (mask),
        .cken_gap_jl            (gap),
        .ctu_dbg_cken_pre_jl    (dbg),
        .ctu_misc_cken_pre_jl   (misc),
        .ctu_jbusl_cken_pre_jl  (jbusl),
        .ctu_jbusr_cken_pre_jl  (jbusr),
        .ctu_jbi_cken_pre_jl    (jbi),
        .ctu_iob_cken_pre_jl    (iob),
        .ctu_efc_cken_pre_jl    (efc),
        .ctu_dram02_cken_pre_jl (dram02),
        .ctu_dram13_cken_pre_jl (dram13),
        .clsp_ctrl_srarm_pre_jl (srarm),
        .seq_done_jl            (done)
    );

    int passes = 0;
    int checks = 0;
    logic [10:0] exp_q[$];

    // Reference model: enables follow closed-form edge times from the ramp/drain start.
    int         mode = MI;
    int         e = 0;
    int         n0 = 0;
    int         m0 = 0;
    int         g = 0;
    logic [8:0] on_m = '0;
    logic       srarm_m = 1'b0;
    logic       done_m = 1'b0;
    logic       sprev_m = 1'b1;

    function automatic int geff(input logic [3:0] v);
        if (!STAG) return 0;
        return (v == 4'd0) ? 1 : int'(v);
    endfunction

    function automatic int plen(input int gg);
        return STAG ? 9 * gg : 1;
    endfunction

    function automatic logic [8:0] up_on(input int ee, input int s, input int gg);
        logic [8:0] r;
        for (int k = 0; k < 9; k++) r[k] = (ee >= s + k * gg);
        return r;
    endfunction

    function automatic logic [8:0] down_on(input int ee, input int s, input int gg);
        logic [8:0] r;
        for (int k = 0; k < 9; k++) r[k] = (ee < s + (8 - k) * gg);
        return r;
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, e);
    endtask

    task automatic model_step();
        logic [10:0] x;
        e++;
        x = rst_n ? {on_m & mask, srarm_m, done_m} : 11'h0;
        if (!rst_n) begin
            mode = MI; on_m = '0; srarm_m = 1'b0; done_m = 1'b0; sprev_m = 1'b1;
        end else begin
            done_m = 1'b0;
            if (!start) begin
                mode = MI; on_m = '0; srarm_m = 1'b0;
            end else begin
                case (mode)
                    MI: begin
                        on_m = '0;
                        if (!sprev_m) begin
                            mode = MU; n0 = e; g = geff(gap);
                            on_m = up_on(e, n0, g);
                        end
                    end
                    MU: begin
                        if (e >= n0 + plen(g)) begin
                            mode = MR; srarm_m = 1'b1; done_m = 1'b1; on_m = '1;
                        end else begin
                            on_m = up_on(e, n0, g);
                        end
                    end
                    MR: begin
                        if (stop) begin
                            mode = MD; m0 = e; g = geff(gap); srarm_m = 1'b0;
                            on_m = down_on(e, m0, g);
                        end
                    end
                    default: begin
                        on_m = down_on(e, m0, g);
                        if (e >= m0 + plen(g)) begin
                            mode = MI; on_m = '0;
                        end
                    end
                endcase
            end
            sprev_m = start;
        end
        exp_q.push_back(x);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("outputs", act, exp_q.pop_front());
    end

    initial begin
        run(3);
        rst_n = 1'b1;
        run(2);

        // basic ramp gap 3, then drain gap 2
        gap = 4'd3; mask = 9'h1FF; start = 1'b1;
        run(32);
        gap = 4'd2; stop = 1'b1;
        run(2);
        stop = 1'b0;
        run(20);

        // dbg masked, gap 0 behaves as 1
        start = 1'b0; run(2);
        mask = 9'h0FE; gap = 4'd0; start = 1'b1;
        run(14);
        stop = 1'b1; run(1); stop = 1'b0;
        run(12);

        // abort mid-ramp then restart
        start = 1'b0; run(2);
        mask = 9'h1FF; gap = 4'd2; start = 1'b1;
        run(9);
        start = 1'b0; run(3);
        start = 1'b1; run(25);
        stop = 1'b1; run(1); stop = 1'b0;
        run(22);

        // stop held from the start edge
        start = 1'b0; run(2);
        gap = 4'd1; stop = 1'b1; start = 1'b1;
        run(20);
        stop = 1'b0; run(3);

        // async reset mid-ramp, start held high across release
        start = 1'b0; run(2);
        gap = 4'd3; start = 1'b1;
        run(8);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", act, 11'h0);
        run(2);
        rst_n = 1'b1;
        run(5);
        start = 1'b0; run(1);
        start = 1'b1; run(30);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (start == 1'b0) begin
                if ($urandom_range(3) == 0) start = 1'b1;
            end else if ($urandom_range(59) == 0) begin
                start = 1'b0;
            end
            stop = ($urandom_range(5) == 0);
            if ($urandom_range(3) == 0) mask = 9'($urandom);
            if ((mode == MI || mode == MR) && $urandom_range(3) == 0) gap = 4'($urandom);
            cycle();
        end

        start = 1'b0; stop = 1'b0;
        run(3);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
